// File: rtl/diff_serial_tx.sv
// Serialiser with a valid/ready word input and a tristatable differential output pair.
// Bits leave from a registered O; OB is its complement, and T floats both legs.
module diff_serial_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter logic        IDLE_LEVEL = 1'b0,
    parameter string       MSB_FIRST  = "TRUE"
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] D,
    input  logic             VALID,
    output logic             READY,
    input  logic             T,
    output wire              O,
    output wire              OB,
    output logic             BUSY
);

    localparam int unsigned    CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam bit             MSB  = (MSB_FIRST == "TRUE");

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shift_r;
    logic [CW-1:0]    cnt_r;
    logic             o_r;
    logic             busy_r;
    logic             ready_r;

    logic             accept_s;
    logic             first_bit_s;
    logic             next_bit_s;
    logic [WIDTH-1:0] load_s;
    logic [WIDTH-1:0] advance_s;

    // Handshake decode and bit-order selection; the register holds only the bits still to send
    always_comb begin
        accept_s = VALID & ready_r;
        if (MSB) begin
            first_bit_s = D[WIDTH-1];
            load_s      = {D[WIDTH-2:0], 1'b0};
            next_bit_s  = shift_r[WIDTH-1];
            advance_s   = {shift_r[WIDTH-2:0], 1'b0};
        end else begin
            first_bit_s = D[0];
            load_s      = {1'b0, D[WIDTH-1:1]};
            next_bit_s  = shift_r[0];
            advance_s   = {1'b0, shift_r[WIDTH-1:1]};
        end
    end

    // Word FSM: acceptance has priority so a word taken on the last-bit cycle follows with no gap
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= IDLE;
            shift_r <= '0;
            cnt_r   <= '0;
            o_r     <= IDLE_LEVEL;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else if (accept_s) begin
            state_r <= SHIFT;
            shift_r <= load_s;
            cnt_r   <= '0;
            o_r     <= first_bit_s;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                SHIFT: begin
                    cnt_r <= cnt_r + CW'(1'b1);
                    if (cnt_r == LAST) begin
                        state_r <= IDLE;
                        o_r     <= IDLE_LEVEL;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= SHIFT;
                        shift_r <= advance_s;
                        o_r     <= next_bit_s;
                        busy_r  <= 1'b1;
                        ready_r <= ((cnt_r + CW'(1'b1)) == LAST);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    o_r     <= IDLE_LEVEL;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign READY = ready_r & RST_N;
    assign BUSY  = busy_r;
    assign O     = T ? 1'bz : o_r;
    assign OB    = T ? 1'bz : ~o_r;

endmodule

// File: tb/tb_diff_serial_tx.sv
// Scoreboard bench for diff_serial_tx: an MSB-first and an LSB-first instance share stimulus,
// a word-level model predicts each cycle, and a negedge monitor compares.
module tb_diff_serial_tx;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         VALID;
    logic         T;
    logic [W-1:0] D;

    wire  o_m, ob_m, o_l, ob_l;
    logic rdy_m, busy_m, rdy_l, busy_l;

    always #5 CLK = ~CLK;

    diff_serial_tx #(.WIDTH(W), .IDLE_LEVEL(1'b0), .MSB_FIRST("TRUE")) u_msb (
        .CLK(CLK), .RST_N(RST_N), .D(D), .VALID(VALID), .READY(rdy_m),
        .T(T), .O(o_m), .OB(ob_m), .BUSY(busy_m)
    );

    diff_serial_tx #(.WIDTH(W), .IDLE_LEVEL(1'b1), .MSB_FIRST("FALSE")) u_lsb (
        .CLK(CLK), .RST_N(RST_N), .D(D), .VALID(VALID), .READY(rdy_l),
        .T(T), .O(o_l), .OB(ob_l), .BUSY(busy_l)
    );

    typedef struct {
        logic o_msb;
        logic o_lsb;
        logic busy;
        logic rdy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the word in flight and how many of its bits have appeared on O
    logic [W-1:0] m_word   = '0;
    int           m_k      = 0;
    bit           m_active = 1'b0;
    bit           m_rdy    = 1'b0;
    bit           m_acc    = 1'b0;

    task automatic step();
        exp_t e;
        @(posedge CLK);
        m_acc = 1'b0;
        if (!RST_N) begin
            m_active = 1'b0;
            m_k      = 0;
            m_rdy    = 1'b0;
        end else begin
            m_acc = VALID && m_rdy;
            if (m_acc) begin
                m_word   = D;
                m_k      = 1;
                m_active = 1'b1;
            end else if (m_active && m_k < W) begin
                m_k++;
            end else begin
                m_active = 1'b0;
            end
            m_rdy = !m_active || (m_k == W);
        end
        e.busy  = m_active;
        e.rdy   = m_rdy;
        e.o_msb = m_active ? m_word[W - m_k] : 1'b0;
        e.o_lsb = m_active ? m_word[m_k - 1] : 1'b1;
        sb.push_back(e);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        bit done;
        done  = 1'b0;
        D     = w;
        VALID = 1'b1;
        for (int i = 0; i < 4 * W && !done; i++) begin
            step();
            if (m_acc) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word %h not accepted, required acceptance within %0d cycles", w, 4 * W);
        end
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %b required %b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (T === 1'b0) begin
                    chk("o_msb",  o_m,  e.o_msb);
                    chk("ob_msb", ob_m, ~e.o_msb);
                    chk("o_lsb",  o_l,  e.o_lsb);
                    chk("ob_lsb", ob_l, ~e.o_lsb);
                end else begin
                    chk("float_msb", (o_m !== ~ob_m), 1'b1);
                    chk("float_lsb", (o_l !== ~ob_l), 1'b1);
                end
                chk("busy_msb",  busy_m, e.busy);
                chk("busy_lsb",  busy_l, e.busy);
                chk("ready_msb", rdy_m,  e.rdy & RST_N);
                chk("ready_lsb", rdy_l,  e.rdy & RST_N);
            end
        end
    end

    initial begin
        RST_N = 1'b0;
        VALID = 1'b0;
        T     = 1'b0;
        D     = '0;
        repeat (3) step();
        RST_N = 1'b1;
        repeat (2) step();

        send(8'hA5);
        VALID = 1'b0;
        repeat (W + 2) step();

        send(8'h01);
        VALID = 1'b0;
        repeat (W + 2) step();

        // Back-to-back with VALID held high across the word boundary
        send(8'hFF);
        send(8'h00);
        VALID = 1'b0;
        repeat (W + 2) step();

        // Float bits 3..5, then bits 6..8 must resume on schedule
        send(8'hA5);
        VALID = 1'b0;
        repeat (2) step();
        T = 1'b1;
        repeat (3) step();
        T = 1'b0;
        repeat (W) step();

        // Reset during bit 4 with a competing VALID
        send(8'hA5);
        VALID = 1'b0;
        repeat (3) step();
        RST_N = 1'b0;
        VALID = 1'b1;
        D     = 8'h3C;
        step();
        RST_N = 1'b1;
        VALID = 1'b0;
        repeat (3) step();

        // New D offered mid-word but withdrawn before the last bit
        send(8'hA5);
        D = 8'h5A;
        repeat (3) step();
        D = 8'hC3;
        repeat (2) step();
        VALID = 1'b0;
        repeat (W + 2) step();

        repeat (400) begin
            RST_N = ($urandom_range(0, 49) != 0);
            VALID = 1'($urandom_range(0, 1));
            D     = W'($urandom);
            T     = ($urandom_range(0, 9) == 0);
            step();
        end

        RST_N = 1'b1;
        VALID = 1'b0;
        T     = 1'b0;
        repeat (W + 2) step();
        @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
